bft_pi_switch: RTL and testbench

Four-port, bufferless, deflection-routed pi switch for the butterfly-fat-tree (BFT) packet network. It sits at an internal tree level between leaf-side ports (left/right children) and root-side ports (up-left/up-right parents). Every cycle it routes every valid input packet to exactly one output through a registered crossbar. Packets that lose arbitration are deflected rather than dropped or stalled.

---
 rtl/bft_pkg.sv | 25 ++
 rtl/pi_route_decode.sv | 33 +++
 rtl/bft_pi_switch.sv | 111 +++++++++++
 tb/tb_bft_pi_switch.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// Shared definitions for the butterfly-fat-tree packet network:
// packet geometry helpers and the port direction encoding.
package bft_pkg;

    typedef enum logic [1:0] {
        L  = 2'd0,
        R  = 2'd1,
        UL = 2'd2,
        UR = 2'd3
    } dir_e;

    // Packet layout is {valid, dest[A-1:0], payload}.
    function automatic int p_sz(input int num_leaves, input int payload_sz);
        return 1 + $clog2(num_leaves) + payload_sz;
    endfunction

    function automatic int valid_idx(input int pkt_sz);
        return pkt_sz - 1;
    endfunction

    function automatic int dest_lo(input int payload_sz);
        return payload_sz;
    endfunction

endpackage

// File: rtl/pi_route_decode.sv
// Per-input route decode: is the packet valid, does it head down into this
// subtree, and if so towards which child.
module pi_route_decode
    import bft_pkg::*;
#(
    parameter int num_leaves = 4,
    parameter int payload_sz = 0,
    parameter int addr       = 0,
    parameter int level      = 1,
    parameter int p_sz       = bft_pkg::p_sz(num_leaves, payload_sz)
) (
    input  logic [p_sz-1:0] pkt,
    output logic            valid,
    output logic            want_down,
    output logic            want_right
);

    localparam int A      = $clog2(num_leaves);
    localparam int V_IDX  = valid_idx(p_sz);
    localparam int D_LO   = dest_lo(payload_sz);
    localparam logic [A-level-1:0] ADDR_V = (A-level)'(addr);

    logic [A-1:0] dest;

    always_comb begin
        dest       = pkt[D_LO +: A];
        valid      = pkt[V_IDX];
        // Bits above this level identify the subtree; matching means "stay below us".
        want_down  = (dest[A-1:level] == ADDR_V);
        want_right = dest[level-1];
    end

endmodule

// File: rtl/bft_pi_switch.sv
// Four-port bufferless deflection-routed pi switch: fixed-priority allocation
// of every valid input to a distinct output, followed by registered outputs.
module bft_pi_switch
    import bft_pkg::*;
#(
    parameter int num_leaves = 4,
    parameter int payload_sz = 0,
    parameter int addr       = 0,
    parameter int level      = 1,
    parameter int p_sz       = bft_pkg::p_sz(num_leaves, payload_sz)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [p_sz-1:0] l_bus_i,
    input  logic [p_sz-1:0] r_bus_i,
    input  logic [p_sz-1:0] ul_bus_i,
    input  logic [p_sz-1:0] ur_bus_i,
    output logic [p_sz-1:0] l_bus_o,
    output logic [p_sz-1:0] r_bus_o,
    output logic [p_sz-1:0] ul_bus_o,
    output logic [p_sz-1:0] ur_bus_o
);

    // Inputs and outputs are both indexed by dir_e (L, R, UL, UR).
    logic [p_sz-1:0] in_pkt [4];
    logic [3:0]      in_valid;
    logic [3:0]      in_down;
    logic [3:0]      in_right;

    logic [p_sz-1:0] out_d [4];
    logic [p_sz-1:0] out_q [4];
    logic [3:0]      taken_d;
    logic [1:0]      src_d;
    dir_e            dst_d;
    logic            placed_d;

    assign in_pkt[L]  = l_bus_i;
    assign in_pkt[R]  = r_bus_i;
    assign in_pkt[UL] = ul_bus_i;
    assign in_pkt[UR] = ur_bus_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            pi_route_decode #(
                .num_leaves(num_leaves),
                .payload_sz(payload_sz),
                .addr      (addr),
                .level     (level),
                .p_sz      (p_sz)
            ) u_dec (
                .pkt       (in_pkt[gi]),
                .valid     (in_valid[gi]),
                .want_down (in_down[gi]),
                .want_right(in_right[gi])
            );
        end
    endgenerate

    always_comb begin
        taken_d  = '0;
        src_d    = '0;
        dst_d    = L;
        placed_d = 1'b0;
        for (int j = 0; j < 4; j++) begin
            out_d[j] = '0;
        end
        // Priority ul, ur, l, r maps to direction index (k+2) mod 4.
        for (int k = 0; k < 4; k++) begin
            src_d    = 2'(k + 2);
            placed_d = 1'b0;
            dst_d    = L;
            if (in_valid[src_d]) begin
                if (in_down[src_d]) begin
                    dst_d    = in_right[src_d] ? R : L;
                    placed_d = !taken_d[dst_d];
                end else if (!taken_d[UL]) begin
                    dst_d    = UL;
                    placed_d = 1'b1;
                end else if (!taken_d[UR]) begin
                    dst_d    = UR;
                    placed_d = 1'b1;
                end
                // Deflection: with four inputs and four outputs a free slot always exists.
                for (int j = 0; j < 4; j++) begin
                    if (!placed_d && !taken_d[j]) begin
                        dst_d    = dir_e'(2'(j));
                        placed_d = 1'b1;
                    end
                end
                taken_d[dst_d] = 1'b1;
                out_d[dst_d]   = in_pkt[src_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (reset) begin
                out_q[j] <= '0;
            end else begin
                out_q[j] <= out_d[j];
            end
        end
    end

    assign l_bus_o  = out_q[L];
    assign r_bus_o  = out_q[R];
    assign ul_bus_o = out_q[UL];
    assign ur_bus_o = out_q[UR];

endmodule

// File: tb/tb_bft_pi_switch.sv
// Directed and exhaustive checks of the pi switch at N=4, level=1, addr=0,
// packets {v,d1,d0}.
module tb_bft_pi_switch;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] l_bus_i, r_bus_i, ul_bus_i, ur_bus_i;
    logic [2:0] l_bus_o, r_bus_o, ul_bus_o, ur_bus_o;

    int n_checks = 0;
    int n_fail   = 0;

    bft_pi_switch #(
        .num_leaves(4),
        .payload_sz(0),
        .addr      (0),
        .level     (1),
        .p_sz      (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .l_bus_i (l_bus_i),
        .r_bus_i (r_bus_i),
        .ul_bus_i(ul_bus_i),
        .ur_bus_i(ur_bus_i),
        .l_bus_o (l_bus_o),
        .r_bus_o (r_bus_o),
        .ul_bus_o(ul_bus_o),
        .ur_bus_o(ur_bus_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic drive(input logic [2:0] ul, input logic [2:0] ur,
                         input logic [2:0] l, input logic [2:0] r);
        ul_bus_i = ul;
        ur_bus_i = ur;
        l_bus_i  = l;
        r_bus_i  = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output word packs {ul_o, ur_o, l_o, r_o}.
    function automatic logic [11:0] outs();
        return {ul_bus_o, ur_bus_o, l_bus_o, r_bus_o};
    endfunction

    // Per valid packet value (100..111) a 4-bit count, plus count of
    // invalid slots carrying nonzero bits in the top nibble.
    function automatic logic [19:0] census(input logic [11:0] w);
        logic [19:0] c;
        logic [2:0]  p;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            p = w[i*3 +: 3];
            if (p[2]) c[(int'(p[1:0]))*4 +: 4] = c[(int'(p[1:0]))*4 +: 4] + 4'd1;
            else if (p != 3'b000) c[19:16] = c[19:16] + 4'd1;
        end
        return c;
    endfunction

    initial begin
        logic [11:0] v;
        logic [19:0] exp_c;

        reset = 1'b1;
        drive(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        tick();
        check("reset_cyc1", 32'(outs()), 32'h0);
        drive(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        tick();
        check("reset_cyc2", 32'(outs()), 32'h0);
        reset = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        tick();
        check("idle", 32'(outs()), 32'h0);

        // Expected words are {ul_o, ur_o, l_o, r_o}.
        drive(3'b000, 3'b000, 3'b101, 3'b000);
        tick();
        check("down_l_to_r", 32'(outs()), 32'({3'b000, 3'b000, 3'b000, 3'b101}));

        drive(3'b000, 3'b100, 3'b000, 3'b000);
        tick();
        check("down_ur_to_l", 32'(outs()), 32'({3'b000, 3'b000, 3'b100, 3'b000}));

        drive(3'b100, 3'b100, 3'b000, 3'b000);
        tick();
        check("down_conflict", 32'(outs()), 32'({3'b000, 3'b000, 3'b100, 3'b100}));

        drive(3'b000, 3'b000, 3'b110, 3'b111);
        tick();
        check("up_route", 32'(outs()), 32'({3'b110, 3'b111, 3'b000, 3'b000}));

        drive(3'b110, 3'b111, 3'b110, 3'b111);
        tick();
        check("full_load", 32'(outs()), 32'({3'b110, 3'b111, 3'b110, 3'b111}));

        // ul takes r; ur deflects to first free (l); invalid input ignored.
        drive(3'b101, 3'b101, 3'b011, 3'b000);
        tick();
        check("deflect_order", 32'(outs()), 32'({3'b000, 3'b000, 3'b101, 3'b101}));

        // r_i wants up but both parents taken by ul_i/ur_i; deflected to l.
        drive(3'b111, 3'b110, 3'b000, 3'b111);
        tick();
        check("up_deflect", 32'(outs()), 32'({3'b111, 3'b110, 3'b111, 3'b000}));

        // l_i wants l but ur_i already holds it; l_i deflects to r.
        drive(3'b000, 3'b100, 3'b100, 3'b000);
        tick();
        check("down_turnaround", 32'(outs()), 32'({3'b000, 3'b000, 3'b100, 3'b100}));

        // Down packet placed at r, up packet at ul; ur_i (up) falls to ur.
        drive(3'b110, 3'b111, 3'b000, 3'b101);
        tick();
        check("mixed", 32'(outs()), 32'({3'b110, 3'b111, 3'b000, 3'b101}));

        for (int c = 0; c < 4096; c++) begin
            v = 12'(c);
            drive(v[11:9], v[8:6], v[5:3], v[2:0]);
            if (c == 2000) begin
                reset = 1'b1;
                tick();
                check("mid_reset", 32'(outs()), 32'h0);
                reset = 1'b0;
            end else begin
                tick();
                exp_c = census(v);
                exp_c[19:16] = 4'd0;
                check($sformatf("sweep_%0d", c), 32'(census(outs())), 32'(exp_c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
